// File: rtl/autoapproach_stream.sv
// Piezo auto-approach engine: DMA-loaded step waveform, DAC step / settle / ADC compare loop.
// Define AUTOAPPROACH_DEBOUNCE_EN to build the consecutive-hit debounce counter.
module autoapproach_stream #(
  parameter int unsigned DAC_WID       = 24,
  parameter int unsigned DAC_DATA_WID  = 20,
  parameter int unsigned ADC_WID       = 24,
  parameter int unsigned TIMER_WID     = 32,
  parameter int unsigned WORD_WID      = 24,
  parameter int unsigned WORD_AMNT_WID = 11,
  parameter int unsigned WORD_AMNT     = 2047,
  parameter int unsigned RAM_WID       = 32,
  parameter int unsigned RAM_WORD_WID  = 16,
  parameter int unsigned RAM_WORD_INCR = 2,
  parameter int unsigned HIT_WID       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     loop,
  input  logic                     polarity,
  input  logic [ADC_WID-1:0]       setpoint,
  input  logic [TIMER_WID-1:0]     time_to_wait,
  input  logic [HIT_WID-1:0]       hit_count,
  output logic                     stopped,
  output logic                     detected,
  output logic [WORD_AMNT_WID-1:0] step_index,
  input  logic                     refresh_start,
  input  logic [RAM_WID-1:0]       start_addr,
  output logic                     refresh_finished,
  output logic [RAM_WID-1:0]       ram_dma_addr,
  output logic                     ram_read,
  input  logic                     ram_valid,
  input  logic [RAM_WORD_WID-1:0]  ram_word,
  output logic                     dac_arm,
  output logic [DAC_WID-1:0]       dac_out,
  input  logic                     dac_finished,
  output logic                     adc_arm,
  input  logic                     adc_finished,
  input  logic [ADC_WID-1:0]       measurement
);
  localparam int unsigned BUF_DEPTH = WORD_AMNT + 1;
  localparam int unsigned BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned HI_WID    = WORD_WID - RAM_WORD_WID;
  localparam logic [WORD_AMNT_WID-1:0] LAST_IDX = WORD_AMNT_WID'(WORD_AMNT);

  typedef enum logic [2:0] {
    S_IDLE, S_DAC_SET, S_SETTLE, S_MEASURE, S_COMPARE, S_STEP, S_DONE
  } run_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_GAP, R_DONE} ref_state_t;

  logic [WORD_WID-1:0] buffer [BUF_DEPTH];

  run_state_t                 state, state_d;
  logic [WORD_AMNT_WID-1:0]   index, index_d, step_index_d;
  logic [TIMER_WID-1:0]       timer, timer_d, ttw_l, ttw_d;
  logic                       loop_l, loop_d, pol_l, pol_d;
  logic signed [ADC_WID-1:0]  setpoint_l, setpoint_d, meas_l, meas_d;
  logic                       dac_arm_d, adc_arm_d, stopped_d, detected_d;
  logic                       dac_load, hit, detect;

  ref_state_t                 ref_state, ref_state_d;
  logic [RAM_WID-1:0]         addr_d;
  logic                       ram_read_d, refresh_finished_d, ref_busy;
  logic [WORD_AMNT_WID-1:0]   wr_idx, wr_idx_d;
  logic                       half, half_d, ref_last, ref_last_d, buf_we;
  logic [RAM_WORD_WID-1:0]    low_word, low_word_d;
  logic [WORD_WID-1:0]        buf_wdata;

`ifdef AUTOAPPROACH_DEBOUNCE_EN
  logic [HIT_WID-1:0] hit_cnt, hit_cnt_d, hit_cnt_next, hit_req, hit_req_d;
`else
  logic [HIT_WID-1:0] unused_hit_count;
  assign unused_hit_count = hit_count;
`endif
  logic [DAC_DATA_WID-1:0] unused_dac_data;
  assign unused_dac_data = dac_out[DAC_DATA_WID-1:0];

  assign ref_busy = (ref_state == R_REQ) || (ref_state == R_GAP);

  // Run FSM next-state and register updates
  always_comb begin
    state_d      = state;
    index_d      = index;
    timer_d      = timer;
    ttw_d        = ttw_l;
    loop_d       = loop_l;
    pol_d        = pol_l;
    setpoint_d   = setpoint_l;
    meas_d       = meas_l;
    dac_arm_d    = dac_arm;
    adc_arm_d    = adc_arm;
    stopped_d    = stopped;
    detected_d   = detected;
    step_index_d = step_index;
    dac_load     = 1'b0;
    hit          = pol_l ? (meas_l <= setpoint_l) : (meas_l >= setpoint_l);
`ifdef AUTOAPPROACH_DEBOUNCE_EN
    hit_cnt_d    = hit_cnt;
    hit_req_d    = hit_req;
    hit_cnt_next = !hit ? '0 : ((&hit_cnt) ? hit_cnt : hit_cnt + HIT_WID'(1));
    detect       = (hit_cnt_next >= hit_req);
`else
    detect       = hit;
`endif
    case (state)
      S_IDLE: begin
        if (arm && !ref_busy) begin
          loop_d     = loop;
          pol_d      = polarity;
          setpoint_d = setpoint;
          ttw_d      = time_to_wait;
          index_d    = '0;
`ifdef AUTOAPPROACH_DEBOUNCE_EN
          hit_cnt_d  = '0;
          hit_req_d  = (hit_count == '0) ? HIT_WID'(1) : hit_count;
`endif
          state_d    = S_DAC_SET;
        end
      end
      // dac_arm low here means the handshake has not been opened yet
      S_DAC_SET: begin
        if (!dac_arm) begin
          if (!arm) begin
            state_d = S_IDLE;
          end else begin
            dac_arm_d    = 1'b1;
            dac_load     = 1'b1;
            step_index_d = index;
          end
        end else if (dac_finished) begin
          dac_arm_d = 1'b0;
          timer_d   = '0;
          state_d   = arm ? S_SETTLE : S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!arm)                state_d = S_IDLE;
        else if (timer == ttw_l) state_d = S_MEASURE;
        else                     timer_d = timer + TIMER_WID'(1);
      end
      S_MEASURE: begin
        if (!adc_arm) begin
          if (!arm) state_d   = S_IDLE;
          else      adc_arm_d = 1'b1;
        end else if (adc_finished) begin
          adc_arm_d = 1'b0;
          meas_d    = measurement;
          state_d   = arm ? S_COMPARE : S_IDLE;
        end
      end
      S_COMPARE: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else begin
`ifdef AUTOAPPROACH_DEBOUNCE_EN
          hit_cnt_d = hit_cnt_next;
`endif
          if (detect) begin
            stopped_d  = 1'b1;
            detected_d = 1'b1;
            state_d    = S_DONE;
          end else if (index != LAST_IDX) begin
            index_d = index + WORD_AMNT_WID'(1);
            state_d = S_STEP;
          end else if (loop_l) begin
            index_d = '0;
            state_d = S_STEP;
          end else begin
            stopped_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      // STEP opens the next DAC handshake directly so the next word goes out one cycle after COMPARE
      S_STEP: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else begin
          dac_arm_d    = 1'b1;
          dac_load     = 1'b1;
          step_index_d = index;
          state_d      = S_DAC_SET;
        end
      end
      S_DONE: begin
        if (!arm) begin
          stopped_d  = 1'b0;
          detected_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      index      <= '0;
      timer      <= '0;
      ttw_l      <= '0;
      loop_l     <= 1'b0;
      pol_l      <= 1'b0;
      setpoint_l <= '0;
      meas_l     <= '0;
      dac_arm    <= 1'b0;
      adc_arm    <= 1'b0;
      stopped    <= 1'b0;
      detected   <= 1'b0;
      step_index <= '0;
    end else begin
      state      <= state_d;
      index      <= index_d;
      timer      <= timer_d;
      ttw_l      <= ttw_d;
      loop_l     <= loop_d;
      pol_l      <= pol_d;
      setpoint_l <= setpoint_d;
      meas_l     <= meas_d;
      dac_arm    <= dac_arm_d;
      adc_arm    <= adc_arm_d;
      stopped    <= stopped_d;
      detected   <= detected_d;
      step_index <= step_index_d;
    end
  end

`ifdef AUTOAPPROACH_DEBOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
      hit_req <= HIT_WID'(1);
    end else begin
      hit_cnt <= hit_cnt_d;
      hit_req <= hit_req_d;
    end
  end
`endif

  // Refresh FSM: two DMA reads (low, then high) per buffer word
  always_comb begin
    ref_state_d        = ref_state;
    addr_d             = ram_dma_addr;
    ram_read_d         = ram_read;
    refresh_finished_d = refresh_finished;
    wr_idx_d           = wr_idx;
    half_d             = half;
    ref_last_d         = ref_last;
    low_word_d         = low_word;
    buf_we             = 1'b0;
    buf_wdata          = {ram_word[HI_WID-1:0], low_word};
    case (ref_state)
      R_IDLE: begin
        if (refresh_start && (state == S_IDLE) && !arm) begin
          addr_d      = start_addr;
          ram_read_d  = 1'b1;
          wr_idx_d    = '0;
          half_d      = 1'b0;
          ref_last_d  = 1'b0;
          ref_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (ram_valid) begin
          ram_read_d  = 1'b0;
          addr_d      = ram_dma_addr + RAM_WID'(RAM_WORD_INCR);
          ref_state_d = R_GAP;
          if (!half) begin
            low_word_d = ram_word;
            half_d     = 1'b1;
          end else begin
            buf_we = 1'b1;
            half_d = 1'b0;
            if (wr_idx == LAST_IDX) ref_last_d = 1'b1;
            else                    wr_idx_d   = wr_idx + WORD_AMNT_WID'(1);
          end
        end
      end
      R_GAP: begin
        if (ref_last) begin
          refresh_finished_d = 1'b1;
          ref_state_d        = R_DONE;
        end else begin
          ram_read_d  = 1'b1;
          ref_state_d = R_REQ;
        end
      end
      R_DONE: begin
        if (!refresh_start) begin
          refresh_finished_d = 1'b0;
          ref_state_d        = R_IDLE;
        end
      end
      default: ref_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_state        <= R_IDLE;
      ram_dma_addr     <= '0;
      ram_read         <= 1'b0;
      refresh_finished <= 1'b0;
      wr_idx           <= '0;
      half             <= 1'b0;
      ref_last         <= 1'b0;
      low_word         <= '0;
    end else begin
      ref_state        <= ref_state_d;
      ram_dma_addr     <= addr_d;
      ram_read         <= ram_read_d;
      refresh_finished <= refresh_finished_d;
      wr_idx           <= wr_idx_d;
      half             <= half_d;
      ref_last         <= ref_last_d;
      low_word         <= low_word_d;
    end
  end

  // Waveform buffer keeps its contents through reset
  always_ff @(posedge clk) begin
    if (buf_we) buffer[wr_idx[BUF_AW-1:0]] <= buf_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           dac_out <= '0;
    else if (dac_load) dac_out <= buffer[index[BUF_AW-1:0]];
  end

endmodule

// File: tb/tb_autoapproach_stream.sv
// Self-checking bench for autoapproach_stream with a 4-word buffer (WORD_AMNT=3).
module tb_autoapproach_stream;
  localparam int unsigned WA = 3;
  localparam int unsigned NW = WA + 1;

  logic        clk = 1'b0;
  logic        rst, arm, loop, polarity;
  logic [23:0] setpoint;
  logic [31:0] time_to_wait;
  logic [7:0]  hit_count;
  logic        stopped, detected;
  logic [10:0] step_index;
  logic        refresh_start, refresh_finished;
  logic [31:0] start_addr, ram_dma_addr;
  logic        ram_read, ram_valid;
  logic [15:0] ram_word;
  logic        dac_arm, dac_finished, adc_arm, adc_finished;
  logic [23:0] dac_out, measurement;

  int checks = 0;
  int errors = 0;

  logic [23:0] bw [NW];
  logic [15:0] ram_mem [2*NW];
  logic [31:0] exp_addr_q [$];
  logic [31:0] obs_addr_q [$];
  logic [23:0] exp_dac_q [$];

  always #5 clk = ~clk;

  autoapproach_stream #(.WORD_AMNT(WA)) dut (
    .clk(clk), .rst(rst), .arm(arm), .loop(loop), .polarity(polarity),
    .setpoint(setpoint), .time_to_wait(time_to_wait), .hit_count(hit_count),
    .stopped(stopped), .detected(detected), .step_index(step_index),
    .refresh_start(refresh_start), .start_addr(start_addr), .refresh_finished(refresh_finished),
    .ram_dma_addr(ram_dma_addr), .ram_read(ram_read), .ram_valid(ram_valid), .ram_word(ram_word),
    .dac_arm(dac_arm), .dac_out(dac_out), .dac_finished(dac_finished),
    .adc_arm(adc_arm), .adc_finished(adc_finished), .measurement(measurement)
  );

  task automatic wait_dac(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dac_arm === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_dac();
    dac_finished = 1'b1;
    @(negedge clk);
    dac_finished = 1'b0;
  endtask

  task automatic serve_adc(input logic [23:0] m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (adc_arm === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      measurement  = m;
      adc_finished = 1'b1;
      @(negedge clk);
      adc_finished = 1'b0;
    end
  endtask

  task automatic start_run(input bit lp, input bit pol, input logic [23:0] sp,
                           input logic [31:0] ttw, input logic [7:0] hc);
    @(negedge clk);
    loop = lp; polarity = pol; setpoint = sp; time_to_wait = ttw; hit_count = hc;
    arm = 1'b1;
  endtask

  task automatic serve_refresh(input logic [31:0] base, output bit ok);
    int served;
    served = 0;
    ok = 1'b0;
    @(negedge clk);
    start_addr = base; refresh_start = 1'b1;
    for (int i = 0; i < 400 && served < 2*NW; i++) begin
      @(negedge clk);
      if (ram_read) begin
        obs_addr_q.push_back(ram_dma_addr);
        ram_valid = 1'b1; ram_word = ram_mem[served];
        @(negedge clk);
        ram_valid = 1'b0;
        served++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (refresh_finished) begin ok = 1'b1; break; end
    end
    refresh_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [72:0] v;
    v = {ram_read, ram_dma_addr, refresh_finished, dac_arm, dac_out, adc_arm, stopped, detected, step_index};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
  endtask

  task automatic test_refresh();
    int rises, extra, n;
    logic prev_fin;
    logic [31:0] exp_a;
    rises = 0; extra = 0; prev_fin = 1'b0;
    exp_addr_q.delete();
    for (int k = 0; k < 2*NW; k++) exp_addr_q.push_back(32'h100 + 32'(2*k));
    @(negedge clk);
    start_addr = 32'h100; refresh_start = 1'b1;
    for (int k = 0; k < 2*NW; k++) begin
      n = 0;
      while (!ram_read && n < 50) begin
        @(negedge clk); n++;
        if (refresh_finished && !prev_fin) rises++;
        prev_fin = refresh_finished;
      end
      checks++;
      if (!ram_read) begin
        errors++; $display("FAIL refresh_req %0d: ram_read=%b expected 1 (timeout)", k, ram_read);
      end else begin
        exp_a = exp_addr_q.pop_front();
        checks++;
        if (ram_dma_addr !== exp_a) begin
          errors++; $display("FAIL refresh_addr %0d: got %h expected %h", k, ram_dma_addr, exp_a);
        end
        ram_valid = 1'b1; ram_word = ram_mem[k];
        @(negedge clk);
        ram_valid = 1'b0;
        checks++;
        if (ram_read !== 1'b0) begin
          errors++; $display("FAIL refresh_read_drop %0d: ram_read=%b expected 0", k, ram_read);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (refresh_finished && !prev_fin) rises++;
      prev_fin = refresh_finished;
      if (ram_read) extra++;
    end
    checks++;
    if (rises !== 1 || refresh_finished !== 1'b1) begin
      errors++; $display("FAIL refresh_finished: rises=%0d level=%b expected 1 rise held high", rises, refresh_finished);
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL refresh_extra_read: got %0d expected 0", extra); end
    refresh_start = 1'b0;
    @(negedge clk);
    checks++;
    if (refresh_finished !== 1'b0) begin
      errors++; $display("FAIL refresh_finished_clear: got %b expected 0", refresh_finished);
    end
  endtask

  task automatic test_ramp_detect();
    bit ok;
    logic [23:0] exp_w;
    logic exp_stop;
    for (int k = 0; k < NW; k++) exp_dac_q.push_back(bw[k]);
    start_run(1'b0, 1'b0, 24'd500, 32'd1, 8'd0);
    @(negedge clk);
    checks++;
    if (dac_arm !== 1'b0) begin errors++; $display("FAIL arm_latency_early: dac_arm=%b expected 0", dac_arm); end
    @(negedge clk);
    checks++;
    if (dac_arm !== 1'b1) begin errors++; $display("FAIL arm_latency: dac_arm=%b expected 1", dac_arm); end
    for (int k = 0; k < NW; k++) begin
      wait_dac(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ramp_dac_arm %0d: got 0 expected 1", k); end
      exp_w = exp_dac_q.pop_front();
      checks++;
      if (dac_out !== exp_w) begin errors++; $display("FAIL ramp_dac_out %0d: got %h expected %h", k, dac_out, exp_w); end
      checks++;
      if (step_index !== 11'(k)) begin errors++; $display("FAIL ramp_index %0d: got %0d expected %0d", k, step_index, k); end
      pulse_dac();
      serve_adc(24'(k*200), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ramp_adc_arm %0d: got 0 expected 1", k); end
      @(negedge clk);
      exp_stop = (k == 3);
      checks++;
      if (stopped !== exp_stop || detected !== exp_stop) begin
        errors++; $display("FAIL ramp_stop %0d: stopped=%b detected=%b expected %b", k, stopped, detected, exp_stop);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dac_out !== bw[3] || step_index !== 11'd3 || stopped !== 1'b1) begin
      errors++; $display("FAIL ramp_hold: dac_out=%h idx=%0d stopped=%b expected %h 3 1", dac_out, step_index, stopped, bw[3]);
    end
    arm = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (stopped !== 1'b0 || detected !== 1'b0) begin
      errors++; $display("FAIL ramp_disarm: stopped=%b detected=%b expected 0 0", stopped, detected);
    end
  endtask

  task automatic test_settle_timing();
    bit ok;
    int cnt;
    logic [31:0] ttws [2];
    ttws[0] = 32'd10; ttws[1] = 32'd0;
    for (int t = 0; t < 2; t++) begin
      start_run(1'b0, 1'b0, 24'h7FFFFF, ttws[t], 8'd0);
      wait_dac(ok);
      pulse_dac();
      cnt = 0;
      while (!adc_arm && cnt < 100) begin @(negedge clk); cnt++; end
      checks++;
      if (cnt !== int'(ttws[t]) + 2) begin
        errors++; $display("FAIL settle_%0d: adc_arm after %0d cycles expected %0d", ttws[t], cnt, ttws[t] + 2);
      end
      serve_adc(24'd0, ok);
      arm = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dac_arm !== 1'b0 || stopped !== 1'b0) begin
        errors++; $display("FAIL settle_abort_%0d: dac_arm=%b stopped=%b expected 0 0", ttws[t], dac_arm, stopped);
      end
    end
  endtask

  task automatic test_no_hit_stop();
    bit ok;
    logic exp_stop;
    start_run(1'b0, 1'b0, 24'd1000, 32'd0, 8'd0);
    for (int k = 0; k < NW; k++) begin
      wait_dac(ok);
      checks++;
      if (step_index !== 11'(k)) begin errors++; $display("FAIL nohit_index %0d: got %0d expected %0d", k, step_index, k); end
      pulse_dac();
      serve_adc((k == 3) ? 24'd999 : 24'(k*100), ok);
      @(negedge clk);
      exp_stop = (k == 3);
      checks++;
      if (stopped !== exp_stop || detected !== 1'b0) begin
        errors++; $display("FAIL nohit_stop %0d: stopped=%b detected=%b expected %b 0", k, stopped, detected, exp_stop);
      end
    end
    arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loop();
    bit ok;
    logic [23:0] exp_w;
    for (int k = 0; k < 6; k++) exp_dac_q.push_back(bw[k % NW]);
    start_run(1'b1, 1'b0, 24'd1000, 32'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      wait_dac(ok);
      exp_w = exp_dac_q.pop_front();
      checks++;
      if (step_index !== 11'(k % NW) || dac_out !== exp_w) begin
        errors++; $display("FAIL loop_step %0d: idx=%0d dac=%h expected %0d %h", k, step_index, dac_out, k % NW, exp_w);
      end
      pulse_dac();
      serve_adc(24'd0, ok);
      if (k == 3) begin
        @(negedge clk);
        checks++;
        if (stopped !== 1'b0) begin errors++; $display("FAIL loop_wrap: stopped=%b expected 0", stopped); end
      end
    end
    arm = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dac_arm !== 1'b0 || stopped !== 1'b0) begin
      errors++; $display("FAIL loop_disarm: dac_arm=%b stopped=%b expected 0 0", dac_arm, stopped);
    end
  endtask

  task automatic test_debounce();
    bit ok;
    int det_at, exp_at;
    logic [23:0] pat [6];
    pat[0] = 24'hFFFF38; pat[1] = 24'hFFFF9C; pat[2] = 24'd50;
    pat[3] = 24'hFFFF38; pat[4] = 24'hFFFF38; pat[5] = 24'hFFFF38;
`ifdef AUTOAPPROACH_DEBOUNCE_EN
    exp_at = 6;
`else
    exp_at = 1;
`endif
    det_at = 0;
    start_run(1'b1, 1'b1, 24'hFFFF9C, 32'd0, 8'd3);
    for (int k = 0; k < 6; k++) begin
      wait_dac(ok);
      pulse_dac();
      serve_adc(pat[k], ok);
      @(negedge clk);
      if (stopped) begin det_at = k + 1; break; end
    end
    checks++;
    if (det_at !== exp_at || detected !== 1'b1) begin
      errors++; $display("FAIL debounce: detect on compare %0d detected=%b expected %0d 1", det_at, detected, exp_at);
    end
    arm = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok;
    int n, bad;
    start_run(1'b0, 1'b0, 24'h7FFFFF, 32'd2, 8'd0);
    wait_dac(ok);
    pulse_dac();
    n = 0;
    while (!adc_arm && n < 50) begin @(negedge clk); n++; end
    arm = 1'b0;
    bad = 0;
    repeat (4) begin @(negedge clk); if (adc_arm !== 1'b1) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_adc_held: adc_arm low in %0d cycles expected 0", bad); end
    measurement = 24'd0; adc_finished = 1'b1;
    @(negedge clk);
    adc_finished = 1'b0;
    checks++;
    if (adc_arm !== 1'b0) begin errors++; $display("FAIL abort_adc_drop: adc_arm=%b expected 0", adc_arm); end
    repeat (3) @(negedge clk);
    checks++;
    if ({dac_arm, stopped, detected} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: dac_arm,stopped,detected=%b expected 000", {dac_arm, stopped, detected});
    end
  endtask

  task automatic test_rst_mid_refresh();
    bit ok;
    int served;
    logic [72:0] v;
    logic [31:0] got;
    served = 0;
    @(negedge clk);
    start_addr = 32'h200; refresh_start = 1'b1;
    for (int i = 0; i < 200 && served < 3; i++) begin
      @(negedge clk);
      if (ram_read) begin
        ram_valid = 1'b1; ram_word = ram_mem[served];
        @(negedge clk);
        ram_valid = 1'b0;
        served++;
      end
    end
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (ram_read) break; end
    rst = 1'b1; refresh_start = 1'b0;
    #1;
    v = {ram_read, ram_dma_addr, refresh_finished, dac_arm, dac_out, adc_arm, stopped, detected, step_index};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL rst_mid_refresh: got %h expected 0", v); end
    @(negedge clk);
    rst = 1'b0;
    ram_mem[0] = 16'h5678;
    obs_addr_q.delete();
    serve_refresh(32'h100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_refresh_done: refresh_finished=%b expected 1", ok); end
    for (int k = 0; k < 2*NW; k++) begin
      got = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 32'hFFFF_FFFF;
      checks++;
      if (got !== 32'h100 + 32'(2*k)) begin
        errors++; $display("FAIL rst_refresh_addr %0d: got %h expected %h", k, got, 32'h100 + 32'(2*k));
      end
    end
    start_run(1'b0, 1'b0, 24'h7FFFFF, 32'd0, 8'd0);
    wait_dac(ok);
    checks++;
    if (dac_out !== 24'hAB5678) begin errors++; $display("FAIL rst_reload_word: got %h expected ab5678", dac_out); end
    arm = 1'b0;
    pulse_dac();
    repeat (3) @(negedge clk);
    checks++;
    if (dac_arm !== 1'b0 || stopped !== 1'b0) begin
      errors++; $display("FAIL rst_reload_abort: dac_arm=%b stopped=%b expected 0 0", dac_arm, stopped);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bw[0] = 24'hAB1234; bw[1] = 24'h222222; bw[2] = 24'h5A0F0F; bw[3] = 24'hFFFFFF;
    for (int i = 0; i < NW; i++) begin
      ram_mem[2*i]     = bw[i][15:0];
      ram_mem[2*i + 1] = {((i == 0) ? 8'h00 : 8'(8'hC0 + i)), bw[i][23:16]};
    end
    rst = 1'b1; arm = 1'b0; loop = 1'b0; polarity = 1'b0; setpoint = '0;
    time_to_wait = '0; hit_count = '0; refresh_start = 1'b0; start_addr = '0;
    ram_valid = 1'b0; ram_word = '0; dac_finished = 1'b0; adc_finished = 1'b0; measurement = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_refresh();
    test_ramp_detect();
    test_settle_timing();
    test_no_hit_stop();
    test_loop();
    test_debounce();
    test_abort();
    test_rst_mid_refresh();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
